// File: rtl/ucode_loader.sv
// ucode_loader: receives a microcode frame byte by byte (address, count, big-endian
// words, optional checksum), writes each word into program memory, then starts the
// CPU and records its completion status.
// Optional feature: define UCODE_LOADER_CKSUM_EN to require a trailing XOR checksum
// byte; without it the CKSUM state is absent and o_error stays 0.
module ucode_loader (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_wr,
  output logic        o_uc_wr,
  output logic [7:0]  o_uc_waddr,
  output logic [15:0] o_uc_wdata,
  output logic        o_run,
  input  logic        i_running,
  input  logic        i_status,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_result,
  output logic        o_error
);

`ifdef UCODE_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StCount, StHi, StLo, StCksum, StRun, StFinish
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StCount, StHi, StLo, StRun, StFinish
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [7:0]  addr_q;
  logic [8:0]  cnt_q;       // 9 bits so that N = 0 can hold 256
  logic [7:0]  hi_q;
  logic        uc_wr_q;
  logic [7:0]  uc_waddr_q;
  logic [15:0] uc_wdata_q;
  logic        first_q;     // first RUN cycle: i_running not yet meaningful
  logic        done_q;
  logic        result_q;
`ifdef UCODE_LOADER_CKSUM_EN
  logic [7:0]  cksum_q;
  logic        error_q;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; strobes are only honoured in the frame-receiving states.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_rx_wr) state_d = StCount;
      StCount: if (i_rx_wr) state_d = StHi;
      StHi:    if (i_rx_wr) state_d = StLo;
      StLo: begin
        if (i_rx_wr) begin
          if (cnt_q == 9'd1) begin
`ifdef UCODE_LOADER_CKSUM_EN
            state_d = StCksum;
`else
            state_d = StRun;
`endif
          end else begin
            state_d = StHi;
          end
        end
      end
`ifdef UCODE_LOADER_CKSUM_EN
      StCksum: if (i_rx_wr) state_d = (i_rx_data == cksum_q) ? StRun : StIdle;
`endif
      StRun:    if (!first_q && !i_running) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Frame datapath, memory write port and run-status registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q     <= 8'd0;
      cnt_q      <= 9'd0;
      hi_q       <= 8'd0;
      uc_wr_q    <= 1'b0;
      uc_waddr_q <= 8'd0;
      uc_wdata_q <= 16'd0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 1'b0;
`ifdef UCODE_LOADER_CKSUM_EN
      cksum_q    <= 8'd0;
      error_q    <= 1'b0;
`endif
    end else begin
      uc_wr_q <= 1'b0;
      first_q <= (state_d == StRun) && (state_q != StRun);
      unique case (state_q)
        StIdle: begin
          if (i_rx_wr) begin
            addr_q   <= i_rx_data;
            done_q   <= 1'b0;
            result_q <= 1'b0;
`ifdef UCODE_LOADER_CKSUM_EN
            error_q  <= 1'b0;
            cksum_q  <= i_rx_data;
`endif
          end
        end
        StCount: begin
          if (i_rx_wr) begin
            cnt_q   <= (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
`ifdef UCODE_LOADER_CKSUM_EN
            cksum_q <= cksum_q ^ i_rx_data;
`endif
          end
        end
        StHi: begin
          if (i_rx_wr) begin
            hi_q    <= i_rx_data;
`ifdef UCODE_LOADER_CKSUM_EN
            cksum_q <= cksum_q ^ i_rx_data;
`endif
          end
        end
        StLo: begin
          if (i_rx_wr) begin
            uc_wr_q    <= 1'b1;
            uc_waddr_q <= addr_q;
            uc_wdata_q <= {hi_q, i_rx_data};
            addr_q     <= addr_q + 8'd1;
            cnt_q      <= cnt_q - 9'd1;
`ifdef UCODE_LOADER_CKSUM_EN
            cksum_q    <= cksum_q ^ i_rx_data;
`endif
          end
        end
`ifdef UCODE_LOADER_CKSUM_EN
        StCksum: begin
          if (i_rx_wr && (i_rx_data != cksum_q)) error_q <= 1'b1;
        end
`endif
        StRun: begin
          if (state_d == StFinish) begin
            done_q   <= 1'b1;
            result_q <= i_status;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_uc_wr    = uc_wr_q;
  assign o_uc_waddr = uc_waddr_q;
  assign o_uc_wdata = uc_wdata_q;
  assign o_run      = (state_q == StRun);
  assign o_busy     = (state_q != StIdle);
  assign o_done     = done_q;
  assign o_result   = result_q;
`ifdef UCODE_LOADER_CKSUM_EN
  assign o_error    = error_q;
`else
  assign o_error    = 1'b0;
`endif

endmodule
